// File: rtl/pixel_readout_seq.sv
// pixel_readout_seq
// Scans a ROWS x COLS pixel array in row-major order. For each pixel it drives
// the row/column select, pulses the pixel reset, waits SETTLE_CYC cycles, then
// captures the ADC code into a FIFO. Firmware drains the FIFO over Wishbone.
//
// Ports:
//   wb_clk_i, rst_n            clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat Wishbone classic slave (regs at 0x0/0x4/0x8/0xC)
//   wbs_dat_o, wbs_ack_o       read data (0 unless acking a read), 1-cycle ack
//   pix_row_o, pix_col_o       registered pixel select
//   pix_rst_o                  pixel reset pulse (PRST state)
//   pix_data_i                 ADC code, captured in SAMPLE
//   irq_o                      registered level interrupt
//
// Build option: define PIXEL_SEQ_TESTPATTERN_EN to build the CTRL.TPAT test
// pattern ({row,col} in place of pix_data_i). Without it TPAT reads 0.
module pixel_readout_seq #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SETTLE_CYC = 4,
    localparam int unsigned ROW_W     = $clog2(ROWS),
    localparam int unsigned COL_W     = $clog2(COLS)
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic [ROW_W-1:0]  pix_row_o,
    output logic [COL_W-1:0]  pix_col_o,
    output logic              pix_rst_o,
    input  logic [DATA_W-1:0] pix_data_i,
    output logic              irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CW-1:0]    SettleLoad = CW'(SETTLE_CYC - 1);
    localparam logic [LW-1:0]    LevelFull  = LW'(FIFO_DEPTH);
    localparam logic [ROW_W-1:0] RowLast    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] ColLast    = COL_W'(COLS - 1);

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegData   = 2'd2;
    localparam logic [1:0] RegThr    = 2'd3;

    typedef enum logic [2:0] {StIdle, StPrst, StSettle, StSample, StNext} state_e;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              cont_q, cont_d;
    logic [4:0]        thr_q, thr_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              wb_acc, wr_en, rd_en;
    logic [1:0]        reg_sel;
    logic              ctrl_wr, thr_wr, status_rd, data_rd;
    logic              start_pulse, clr_pulse;
    logic              busy, pix_rst, push_req, frame_end, last_pix;
    logic              empty, full, push, pop, drop;
    logic [DATA_W-1:0] sample_data, head;
    logic [31:0]       rdata;
    logic              tpat;
    logic              unused_bits;

    // ---------------- Wishbone decode ----------------
    always_comb begin
        ack_d       = wbs_cyc_i & wbs_stb_i & ~ack_q;
        // Side effects happen in the ack cycle while the master still holds the request.
        wb_acc      = ack_q & wbs_cyc_i & wbs_stb_i;
        reg_sel     = wbs_adr_i[3:2];
        wr_en       = wb_acc & wbs_we_i & wbs_sel_i[0];
        rd_en       = wb_acc & ~wbs_we_i;
        ctrl_wr     = wr_en && (reg_sel == RegCtrl);
        thr_wr      = wr_en && (reg_sel == RegThr);
        status_rd   = rd_en && (reg_sel == RegStatus);
        data_rd     = rd_en && (reg_sel == RegData);
        start_pulse = ctrl_wr & wbs_dat_i[0];
        clr_pulse   = ctrl_wr & wbs_dat_i[2];
        unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1],
                        wbs_dat_i[31:5], wbs_dat_i[3]};
    end

    // ---------------- Optional test pattern ----------------
`ifdef PIXEL_SEQ_TESTPATTERN_EN
    logic                          tpat_q, tpat_d;
    logic [ROW_W+COL_W+DATA_W-1:0] pat_ext;

    always_comb begin
        tpat_d      = ctrl_wr ? wbs_dat_i[3] : tpat_q;
        pat_ext     = {{DATA_W{1'b0}}, row_q, col_q};
        tpat        = tpat_q;
        sample_data = tpat_q ? pat_ext[DATA_W-1:0] : pix_data_i;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tpat_q <= 1'b0;
        end else begin
            tpat_q <= tpat_d;
        end
    end
`else
    always_comb begin
        tpat        = 1'b0;
        sample_data = pix_data_i;
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        last_pix = (row_q == RowLast) && (col_q == ColLast);
        state_d  = state_q;
        unique case (state_q)
            StIdle:   if (start_pulse) state_d = StPrst;
            StPrst:   state_d = StSettle;
            StSettle: if (cnt_q == '0) state_d = StSample;
            StSample: state_d = StNext;
            StNext: begin
                if (last_pix) state_d = cont_q ? StPrst : StIdle;
                else          state_d = StPrst;
            end
            default:  state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pix_rst   = (state_q == StPrst);
        busy      = (state_q != StIdle);
        push_req  = (state_q == StSample);
        frame_end = (state_q == StNext) && last_pix;
    end

    // ---------------- Scan position and settle counter ----------------
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (state_q == StPrst) begin
            cnt_d = SettleLoad;
        end else if ((state_q == StSettle) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
        // Select only moves in NEXT; the last pixel wraps back to (0,0).
        if (state_q == StNext) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // ---------------- FIFO ----------------
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LevelFull);
        head     = mem_q[rd_ptr_q];
        pop      = data_rd & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_pulse) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_data;
        end
    end

    // ---------------- Control / status registers ----------------
    always_comb begin
        cont_d = ctrl_wr ? wbs_dat_i[1] : cont_q;
        thr_d  = thr_wr ? wbs_dat_i[4:0] : thr_q;
        // A new event in the same cycle as the clearing read stays visible.
        ovf_d  = (ovf_q & ~status_rd) | drop;
        done_d = (done_q & ~status_rd) | frame_end;
        irq_d  = ((32'(level_q) >= 32'(thr_q)) && (thr_q != '0)) || ovf_q;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            cont_q   <= 1'b0;
            thr_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            cont_q   <= cont_d;
            thr_q    <= thr_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ---------------- Read mux and outputs ----------------
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegCtrl: begin
                rdata[1] = cont_q;
                rdata[3] = tpat;
            end
            RegStatus: begin
                rdata[0]    = busy;
                rdata[1]    = empty;
                rdata[2]    = full;
                rdata[3]    = ovf_q;
                rdata[4]    = done_q;
                rdata[12:8] = 5'(level_q);
            end
            RegData: begin
                if (!empty) rdata[DATA_W-1:0] = head;
            end
            RegThr: begin
                rdata[4:0] = thr_q;
            end
            default: rdata = '0;
        endcase
        wbs_dat_o = rd_en ? rdata : 32'h0;
        wbs_ack_o = ack_q;
        pix_row_o = row_q;
        pix_col_o = col_q;
        pix_rst_o = pix_rst;
        irq_o     = irq_q;
    end

endmodule

// File: tb/tb_pixel_readout_seq.sv
`timescale 1ns/1ps
module tb_pixel_readout_seq;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int DEPTH   = 16;
    localparam int SETTLE  = 4;
    localparam int PIX_CYC = SETTLE + 3;
    localparam int NPIX    = ROWS * COLS;
`ifdef PIXEL_SEQ_TESTPATTERN_EN
    localparam bit TPAT_BUILD = 1'b1;
`else
    localparam bit TPAT_BUILD = 1'b0;
`endif

    localparam logic [3:0] A_CTRL = 4'h0, A_STATUS = 4'h4, A_DATA = 4'h8, A_THR = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_i = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic [2:0]  row, col;
    logic        prst, irq;
    logic [7:0]  pix_data;
    logic [7:0]  pix_tab [NPIX];

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] mon_e;
    string       mon_n;

    always #5 clk = ~clk;

    // ADC model: each pixel position returns its own table entry.
    always_comb pix_data = pix_tab[{row, col}];

    pixel_readout_seq dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_dat_o  (dat_o),
        .wbs_ack_o  (ack),
        .pix_row_o  (row),
        .pix_col_o  (col),
        .pix_rst_o  (prst),
        .pix_data_i (pix_data),
        .irq_o      (irq)
    );

    // Scoreboard monitor: every read ack is compared against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && ack && !we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got 0x%08h with no read outstanding", dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (dat_o !== mon_e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_n, dat_o, mon_e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        bit got;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a}; dat_i = d; sel = s;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = ack;
        end
        check("wb_ack_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        wb_xfer(1'b1, a, d, 4'hF);
    endtask

    task automatic wb_read(input logic [3:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        wb_xfer(1'b0, a, 32'h0, 4'hF);
    endtask

    function automatic int attempts(input int t, input int npix);
        int n;
        if (t < SETTLE + 2) return 0;
        n = (t - (SETTLE + 2)) / PIX_CYC + 1;
        return (n > npix) ? npix : n;
    endfunction

    // Expected {pix_rst, row, col, irq} in cycle t after START, FIFO initially empty.
    function automatic logic [7:0] exp_trace(input int t, input int npix, input int thr);
        int k, p, a, lvl;
        bit r, ovf, ir;
        logic [2:0] er, ec;
        if (t < npix * PIX_CYC) begin
            k  = t / PIX_CYC;
            p  = k % NPIX;
            r  = (t % PIX_CYC) == 0;
            er = 3'(p / COLS);
            ec = 3'(p % COLS);
        end else begin
            r = 1'b0; er = 3'd0; ec = 3'd0;
        end
        a   = attempts(t - 1, npix);
        lvl = (a > DEPTH) ? DEPTH : a;
        ovf = a > DEPTH;
        ir  = ((thr != 0) && (lvl >= thr)) || ovf;
        return {r, er, ec, ir};
    endfunction

    task automatic trace(input int t0, input int t1, input int npix, input int thr);
        for (int t = t0; t <= t1; t++) begin
            check($sformatf("trace_t%0d", t), {24'd0, prst, row, col, irq},
                  {24'd0, exp_trace(t, npix, thr)});
            wait_cyc(1);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int k, input bit tp);
        if (tp) return 32'(k % NPIX);
        return {24'd0, pix_tab[k % NPIX]};
    endfunction

    task automatic new_table();
        for (int i = 0; i < NPIX; i++) pix_tab[i] = 8'($urandom);
    endtask

    initial begin
        new_table();

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("outputs_in_reset", {ack, dat_o, row, col, prst, irq}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        check("outputs_after_reset", {ack, dat_o, row, col, prst, irq}, '0);
        wb_read(A_STATUS, 32'h0000_0002, "status_reset");
        wb_read(A_DATA,   32'h0,         "data_empty");
        wb_read(A_STATUS, 32'h0000_0002, "status_after_empty_read");
        wb_read(A_THR,    32'h0,         "thr_reset");
        wb_read(A_CTRL,   32'h0,         "ctrl_reset");
        wb_write(A_THR, 32'h15);
        wb_read(A_THR, 32'h15, "thr_write");
        wb_xfer(1'b1, A_THR, 32'h0A, 4'hE);
        wb_read(A_THR, 32'h15, "thr_write_no_sel0");
        wb_write(A_THR, 32'h0);

        // ---- Full frame, THR=4, no reads during the scan ----
        new_table();
        wb_write(A_THR, 32'd4);
        wb_write(A_CTRL, 32'h1);
        trace(0, 451, NPIX, 4);
        wb_read(A_STATUS, 32'h0000_101C, "status_frame_end");
        wb_read(A_STATUS, 32'h0000_1004, "status_sticky_cleared");
        check("irq_level_ge_thr", {31'd0, irq}, 32'd1);
        for (int i = 0; i < DEPTH; i++) wb_read(A_DATA, exp_pix(i, 1'b0), $sformatf("drain1_%0d", i));
        wb_read(A_STATUS, 32'h0000_0002, "status_drained");
        wait_cyc(1);
        check("irq_after_drain", {31'd0, irq}, 32'd0);

        // ---- Pop coincident with push while full ----
        new_table();
        wb_write(A_THR, 32'd0);
        wb_write(A_CTRL, 32'h1);
        wait_cyc(PIX_CYC * DEPTH + SETTLE);
        wb_read(A_DATA, exp_pix(0, 1'b0), "pop_push_full_data");
        wb_read(A_STATUS, 32'h0000_1005, "status_after_pop_push");
        wait_cyc(330);
        check("irq_ovf", {31'd0, irq}, 32'd1);
        wb_read(A_STATUS, 32'h0000_101C, "status_frame2_end");
        wait_cyc(1);
        check("irq_after_ovf_clear", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) wb_read(A_DATA, exp_pix(i, 1'b0), $sformatf("drain2_%0d", i));
        wb_read(A_STATUS, 32'h0000_0002, "status_drained2");

        // ---- Continuous mode, then CONT cleared (with an ignored START) mid-frame ----
        new_table();
        wb_write(A_CTRL, 32'h4);
        wb_write(A_CTRL, 32'h3);
        trace(0, 465, 2 * NPIX, 0);
        wb_write(A_CTRL, 32'h1);
        trace(468, 2 * NPIX * PIX_CYC + 3, 2 * NPIX, 0);
        wb_read(A_STATUS, 32'h0000_101C, "status_cont_end");
        wb_read(A_DATA, exp_pix(0, 1'b0), "cont_data0");
        wb_read(A_DATA, exp_pix(1, 1'b0), "cont_data1");
        wb_read(A_STATUS, 32'h0000_0E00, "status_level14");
        wb_write(A_CTRL, 32'h4);
        wb_read(A_STATUS, 32'h0000_0002, "status_after_clr");

        // ---- Clear coincident with the first push; test pattern when built ----
        new_table();
        wb_write(A_CTRL, 32'h9);
        wait_cyc(SETTLE);
        wb_write(A_CTRL, 32'hC);
        wb_read(A_STATUS, 32'h0000_0003, "status_clr_beats_push");
        wait_cyc(442);
        wb_read(A_STATUS, 32'h0000_101C, "status_tp_end");
        wb_read(A_CTRL, TPAT_BUILD ? 32'h8 : 32'h0, "ctrl_tpat_readback");
        wb_read(A_DATA, exp_pix(1, TPAT_BUILD), "tp_data1");
        wb_read(A_DATA, exp_pix(2, TPAT_BUILD), "tp_data2");
        wb_write(A_CTRL, 32'h4);
        wb_read(A_STATUS, 32'h0000_0002, "status_tp_clr");

        // ---- Reset mid-frame ----
        wb_write(A_THR, 32'd1);
        wb_write(A_CTRL, 32'h3);
        wait_cyc(100);
        check("irq_before_reset", {31'd0, irq}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("outputs_async_reset", {ack, dat_o, row, col, prst, irq}, '0);
        wait_cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(10);
        check("idle_after_reset", {ack, dat_o, row, col, prst, irq}, '0);
        wb_read(A_STATUS, 32'h0000_0002, "status_after_midframe_reset");
        wb_read(A_THR,    32'h0,         "thr_after_midframe_reset");
        wb_read(A_CTRL,   32'h0,         "ctrl_after_midframe_reset");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
